sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Upstream stage of the SHA-256 compression core. Accepts a byte-serial message framed by start/data_last and packs it big-endian into 512-bit blocks. Applies FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit big-endian message bit-length. Each block is handed to the compression core over a valid/ready handshake, and the final block is flagged.

Parameters:
CNT_W, 32, width of the internal message byte counter; the bit-length field is {zeros, byte_count, 3'b000} zero-extended to 64 bits.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a new message; honoured only in IDLE
data_in  input  8  message byte
data_valid  input  1  data_in is valid
data_last  input  1  this byte is the final message byte; sampled only with data_valid
data_ready  output  1  padder can accept a byte this cycle
block_out  output  512  assembled block; byte 0 is at [511:504]
block_valid  output  1  block_out holds a complete block
block_last  output  1  qualifies block_valid; this is the final padded block of the message
block_ready  input  1  compression core accepts block_out
busy  output  1  high in any state other than IDLE
len_err  output  1  sticky flag: byte counter wrapped; cleared by start or reset

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; idx=0, count=0, pad_phase=NONE, buffer=0.
  - block_valid=0, block_last=0, data_ready=0, busy=0, len_err=0, block_out=0.
  - Reset mid-message discards all partial data; no block is emitted.
- States: IDLE, LOAD, FIN, EMIT. data_ready is combinationally equal to (state==LOAD).
- IDLE:
  - start=1 clears buffer, idx, count and len_err, then moves to LOAD.
  - start in any other state is ignored.
- LOAD, on each byte accept (data_valid & data_ready):
  - Byte is written at index idx; idx++ and count++ (modulo 2^CNT_W).
  - len_err is set if count wraps.
- LOAD transitions after an accept:
  - data_last=1: go to FIN with pad_phase=MARKER.
  - Otherwise, idx reaches 64: go to EMIT with block_last=0.
  - data_last with idx reaching 64: go to EMIT (block_last=0) with pad_phase=MARKER kept pending.
- FIN, one cycle:
  - If pad_phase=MARKER: write 0x80 at idx and zero bytes idx+1..63.
    - idx<=55 after the marker: write the length into bytes 56..63, set block_last=1, pad_phase=NONE.
    - Otherwise: block_last=0, pad_phase=LENGTH.
  - If pad_phase=LENGTH: buffer = all zeros plus the length in bytes 56..63; block_last=1.
  - Then go to EMIT.
- EMIT:
  - block_valid=1; block_out and block_last stay stable until the block_ready handshake.
  - On handshake: buffer and idx are cleared.
  - Next state: FIN if pad_phase is not NONE; IDLE if block_last=1; otherwise LOAD.
- Latency:
  - Full non-final data block: block_valid asserts the edge after the 64th byte is accepted.
  - data_last block: block_valid asserts 2 edges after the accepting edge (FIN cycle).
  - Follow-on padding block: block_valid asserts 2 edges after the previous handshake.
- Zero-length messages are unsupported; a message carries at least one byte.
- data_valid while data_ready=0 is ignored; the upstream source holds the byte.

Decomposition:
- Shared header sha256_defs.vh holds:
  - SHA256_BLOCK_BYTES=64, SHA256_LEN_BYTES=8, SHA256_PAD_MARKER=8'h80.
  - State and pad_phase encodings.
- No sub-module; the buffer byte-write and the length insertion are local logic.

Test Plan:
- "TEST" (54 45 53 54, last on byte 3), block_ready=1 -> one block 0x5445535480 00…00, final 8 bytes 0x...20; block_last=1; busy falls the edge after the handshake.
- 56 bytes of 0x61 -> block 1: 56×0x61, 0x80, 7×0x00, block_last=0; block 2: 56×0x00 then 0x00000000000001C0, block_last=1.
- 64 bytes of 0x61 (last on byte 63) -> block 1: 64×0x61, block_last=0; block 2: 0x80, 55×0x00, length 0x200, block_last=1.
- Backpressure: hold block_ready=0 for 5 cycles during EMIT -> block_valid stays 1, block_out unchanged, data_ready=0 throughout; the handshake on cycle 6 proceeds normally.
- Deassert rst_n after 10 bytes of a message -> all outputs return to reset values immediately; a following start plus "abc" yields 0x61626380…, length 0x18, block_last=1.
- start pulsed during LOAD and data_valid pulsed in IDLE -> both ignored; idx and count unchanged.

Source files
------------

// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants, state/pad-phase encodings and the length-field helper for the SHA-256 padder.
package sha256_msg_padder_pkg;

  localparam int SHA256_BLOCK_BYTES = 64;
  localparam int SHA256_LEN_BYTES   = 8;
  localparam logic [7:0] SHA256_PAD_MARKER = 8'h80;
  localparam int LEN_POS = SHA256_BLOCK_BYTES - SHA256_LEN_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIN,
    ST_EMIT
  } state_t;

  typedef enum logic [1:0] {
    PAD_NONE,
    PAD_MARKER,
    PAD_LENGTH
  } pad_phase_t;

  // Overwrites the trailing 8 bytes of a block with the big-endian bit length.
  function automatic logic [511:0] insert_len(input logic [511:0] blk, input logic [63:0] len);
    insert_len = {blk[511:64], len};
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Byte-serial message in, FIPS 180-4 padded 512-bit blocks out; block_valid follows the 64th byte by one edge,
// a last-byte block by two (FIN cycle); EMIT holds block_out/block_last stable and data_ready low until block_ready.
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  input  logic         data_last,
  output logic         data_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready,
  output logic         busy,
  output logic         len_err
);

  state_t             state;
  pad_phase_t         pad_phase;
  logic [6:0]         idx;
  logic [CNT_W-1:0]   count;
  logic [511:0]       buffer;

  logic               accept;
  logic               handshake;
  logic [6:0]         idx_inc;
  logic [CNT_W-1:0]   count_inc;
  logic [63:0]        len_field;
  logic [511:0]       marker_buf;

  assign data_ready = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign block_out  = buffer;
  assign accept     = data_valid & data_ready;
  assign handshake  = block_valid & block_ready;
  assign idx_inc    = idx + 7'd1;
  assign count_inc  = count + CNT_W'(1);
  assign len_field  = 64'({count, 3'b000});

  // Marker at idx, zeros after it, and the length too when it still fits in this block.
  always_comb begin
    marker_buf = buffer;
    for (int i = 0; i < SHA256_BLOCK_BYTES; i++) begin
      if (7'(i) == idx) begin
        marker_buf[511-8*i -: 8] = SHA256_PAD_MARKER;
      end else if (7'(i) > idx) begin
        marker_buf[511-8*i -: 8] = 8'h00;
      end
    end
    if (idx < 7'(LEN_POS)) begin
      marker_buf = insert_len(marker_buf, len_field);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pad_phase   <= PAD_NONE;
      idx         <= '0;
      count       <= '0;
      buffer      <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            buffer     <= '0;
            idx        <= '0;
            count      <= '0;
            len_err    <= 1'b0;
            pad_phase  <= PAD_NONE;
            block_last <= 1'b0;
            state      <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            buffer[{~idx[5:0], 3'b000} +: 8] <= data_in;
            idx   <= idx_inc;
            count <= count_inc;
            if (count_inc == '0) begin
              len_err <= 1'b1;
            end
            if (data_last) begin
              pad_phase <= PAD_MARKER;
            end
            // A full block always goes out first; a pending marker rides along to the next FIN.
            if (idx_inc == 7'(SHA256_BLOCK_BYTES)) begin
              block_valid <= 1'b1;
              block_last  <= 1'b0;
              state       <= ST_EMIT;
            end else if (data_last) begin
              state <= ST_FIN;
            end
          end
        end

        ST_FIN: begin
          if (pad_phase == PAD_MARKER) begin
            buffer <= marker_buf;
            if (idx < 7'(LEN_POS)) begin
              block_last <= 1'b1;
              pad_phase  <= PAD_NONE;
            end else begin
              block_last <= 1'b0;
              pad_phase  <= PAD_LENGTH;
            end
          end else begin
            buffer     <= insert_len('0, len_field);
            block_last <= 1'b1;
            pad_phase  <= PAD_NONE;
          end
          block_valid <= 1'b1;
          state       <= ST_EMIT;
        end

        ST_EMIT: begin
          if (handshake) begin
            buffer      <= '0;
            idx         <= '0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            if (pad_phase != PAD_NONE) begin
              state <= ST_FIN;
            end else if (block_last) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed-vector bench for sha256_msg_padder: table of messages with hand-padded blocks plus timing corner sequences.
module tb_sha256_msg_padder;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_last;
  logic         data_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_last;
  logic         block_ready;
  logic         busy;
  logic         len_err;

  int n_vec = 0;
  int n_err = 0;

  sha256_msg_padder #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_last   (data_last),
    .data_ready  (data_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready),
    .busy        (busy),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           len;
    logic [511:0] msg;
    int           nblk;
    logic [511:0] exp0;
    logic [511:0] exp1;
    logic         last0;
    logic         last1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives bytes from negedge to negedge whenever data_ready is high.
  task automatic send_bytes(input logic [511:0] msg, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      int t;
      t = 0;
      while (!data_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!data_ready) begin
        chk("drv_timeout", 512'(data_ready), 512'(1));
        data_valid = 1'b0;
        return;
      end
      data_in    = msg[511-8*i -: 8];
      data_valid = 1'b1;
      data_last  = with_last && (i == len - 1);
      @(negedge clk);
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic collect(input int tag, input int nblk, input logic [511:0] exp0,
                         input logic [511:0] exp1, input logic last0, input logic last1);
    for (int k = 0; k < nblk; k++) begin
      int t;
      t = 0;
      while (!block_valid && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!block_valid) begin
        chk($sformatf("v%0d_b%0d_timeout", tag, k), 512'(block_valid), 512'(1));
        return;
      end
      chk($sformatf("v%0d_b%0d_data", tag, k), block_out, (k == 0) ? exp0 : exp1);
      chk($sformatf("v%0d_b%0d_last", tag, k), 512'(block_last), 512'((k == 0) ? last0 : last1));
      chk($sformatf("v%0d_b%0d_len_err", tag, k), 512'(len_err), 512'(0));
      @(negedge clk);
    end
    chk($sformatf("v%0d_busy_fall", tag), 512'(busy), 512'(0));
  endtask

  task automatic run_vec(input int v);
    pulse_start();
    fork
      send_bytes(vecs[v].msg, vecs[v].len, 1'b1);
      collect(v, vecs[v].nblk, vecs[v].exp0, vecs[v].exp1, vecs[v].last0, vecs[v].last1);
    join
  endtask

  initial begin
    logic [511:0] exp_ab;
    exp_ab = {16'h6162, 8'h80, 424'h0, 64'h10};

    vecs[0] = '{len: 4, msg: {32'h54455354, 480'h0}, nblk: 1,
                exp0: {32'h54455354, 8'h80, 408'h0, 64'h20}, exp1: '0, last0: 1'b1, last1: 1'b0};
    vecs[1] = '{len: 56, msg: {{56{8'h61}}, 64'h0}, nblk: 2,
                exp0: {{56{8'h61}}, 8'h80, 56'h0}, exp1: {448'h0, 64'h1c0}, last0: 1'b0, last1: 1'b1};
    vecs[2] = '{len: 64, msg: {64{8'h61}}, nblk: 2,
                exp0: {64{8'h61}}, exp1: {8'h80, 440'h0, 64'h200}, last0: 1'b0, last1: 1'b1};
    vecs[3] = '{len: 3, msg: {24'h616263, 488'h0}, nblk: 1,
                exp0: {24'h616263, 8'h80, 416'h0, 64'h18}, exp1: '0, last0: 1'b1, last1: 1'b0};
    vecs[4] = '{len: 55, msg: {{55{8'h62}}, 72'h0}, nblk: 1,
                exp0: {{55{8'h62}}, 8'h80, 64'h1b8}, exp1: '0, last0: 1'b1, last1: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    data_in = 8'h00;
    data_valid = 1'b0;
    data_last = 1'b0;
    block_ready = 1'b1;
    #1;
    chk("rst_block_out", block_out, '0);
    chk("rst_flags", 512'({block_valid, block_last, data_ready, busy, len_err}), 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_vec(v);
    end

    // Latency and backpressure: two-byte message, core stalls five cycles.
    block_ready = 1'b0;
    pulse_start();
    send_bytes({16'h6162, 496'h0}, 2, 1'b1);
    chk("bp_fin_cycle_valid", 512'(block_valid), 512'(0));
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 512'(block_valid), 512'(1));
      chk($sformatf("bp_data_c%0d", c), block_out, exp_ab);
      chk($sformatf("bp_ready_c%0d", c), 512'({data_ready, block_last}), 512'(2'b01));
      @(negedge clk);
    end
    block_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs", 512'({block_valid, busy}), 512'(0));

    // Reset in the middle of a message drops everything immediately.
    pulse_start();
    send_bytes({{10{8'h41}}, 432'h0}, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_block_out", block_out, '0);
    chk("midrst_flags", 512'({block_valid, block_last, data_ready, busy, len_err}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(3);

    // data_valid in IDLE and start during LOAD are both ignored.
    @(negedge clk);
    data_in = 8'h55;
    data_valid = 1'b1;
    data_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_dv_ignored", 512'({busy, data_ready, block_valid}), 512'(0));
    data_valid = 1'b0;
    data_last = 1'b0;
    pulse_start();
    send_bytes({16'h6162, 496'h0}, 2, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_start_ignored", 512'({busy, data_ready, block_valid}), 512'(3'b110));
    fork
      send_bytes({8'h63, 504'h0}, 1, 1'b1);
      collect(9, 1, vecs[3].exp0, '0, 1'b1, 1'b0);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
